// File: rtl/arb_requester_pkg.sv
// arb_requester_pkg: shared defaults, index-width helper and one-hot check for the requester and its arbiter
package arb_requester_pkg;
  localparam int N_DEF = 32;
  localparam int DW_DEF = 8;
  localparam int N_MAX = 1024;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic is_onehot0(input logic [N_MAX-1:0] v);
    return (v & (v - {{(N_MAX-1){1'b0}}, 1'b1})) == '0;
  endfunction
endpackage

// File: rtl/arb_requester_if.sv
// arb_requester_if: client handshakes, arbiter req/gnt, output stream and status (master = requester, slave = environment)
interface arb_requester_if import arb_requester_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF
);
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_data;
  logic [idx_w(N)-1:0] out_id;
  logic [N-1:0] starve;
  logic proto_err;
  modport master (
    input in_valid, in_data, gnt, out_ready,
    output in_ready, req, out_valid, out_data, out_id, starve, proto_err
  );
  modport slave (
    output in_valid, in_data, gnt, out_ready,
    input in_ready, req, out_valid, out_data, out_id, starve, proto_err
  );
endinterface

// File: rtl/arb_requester_slot.sv
// arb_req_slot: one client's holding register, ready/request logic and saturating wait counter with starve flag
module arb_req_slot import arb_requester_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int STARVE_MAX = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_slot_free,
  input  logic          i_gnt,
  input  logic          i_take,
  output logic          o_ready,
  output logic          o_req,
  output logic [DW-1:0] o_data,
  output logic          o_starve
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  logic r_hv;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_cnt;
  logic w_load;
  assign o_req = r_hv & i_slot_free;
  assign o_ready = ~r_hv | i_take;
  assign w_load = i_valid & o_ready;
  assign o_data = r_data;
  assign o_starve = r_cnt == SMAX;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hv <= 1'b0;
      r_data <= '0;
      r_cnt <= '0;
    end else begin
      r_hv <= w_load | (r_hv & ~i_take);
      if (w_load) r_data <= i_data;
      r_cnt <= (~r_hv | i_take) ? '0 : (o_req & ~i_gnt & (r_cnt != SMAX)) ? r_cnt + 1'b1 : r_cnt;
    end
  end
endmodule

// File: rtl/arb_requester.sv
// arb_requester: per-client holding slots feeding a single output register under an external one-hot arbiter grant
module arb_requester import arb_requester_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF,
  parameter int STARVE_MAX = 64
) (
  input logic clk,
  input logic rst_n,
  arb_requester_if.master bus
);
  localparam int IW = idx_w(N);
  logic [N-1:0] w_req;
  logic [N-1:0] w_ready;
  logic [N-1:0] w_starve;
  logic [N-1:0] w_take;
  logic [DW-1:0] w_hold [N];
  logic w_slot_free;
  logic w_gnt_any;
  logic w_legal;
  logic w_accept;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_dat;
  logic r_ov;
  logic r_perr;
  logic [DW-1:0] r_od;
  logic [IW-1:0] r_oid;
  assign w_slot_free = ~r_ov | bus.out_ready;
  assign w_gnt_any = |bus.gnt;
  assign w_legal = is_onehot0(N_MAX'(bus.gnt)) & ~|(bus.gnt & ~w_req);
  assign w_accept = w_gnt_any & w_legal;
  assign w_take = w_accept ? bus.gnt : '0;
  for (genvar i = 0; i < N; i++) begin : g_slot
    arb_req_slot #(.DW(DW), .STARVE_MAX(STARVE_MAX)) u_slot (
      .clk(clk),
      .rst_n(rst_n),
      .i_valid(bus.in_valid[i]),
      .i_data(bus.in_data[i*DW +: DW]),
      .i_slot_free(w_slot_free),
      .i_gnt(bus.gnt[i]),
      .i_take(w_take[i]),
      .o_ready(w_ready[i]),
      .o_req(w_req[i]),
      .o_data(w_hold[i]),
      .o_starve(w_starve[i])
    );
  end
  always_comb begin
    w_idx = '0;
    w_dat = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = w_idx | (bus.gnt[k] ? IW'(k) : '0);
      w_dat = w_dat | (bus.gnt[k] ? w_hold[k] : '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov <= 1'b0;
      r_od <= '0;
      r_oid <= '0;
      r_perr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ov <= 1'b1;
        r_od <= w_dat;
        r_oid <= w_idx;
      end else if (bus.out_ready) r_ov <= 1'b0;
      if (w_gnt_any & ~w_legal) r_perr <= 1'b1;
    end
  end
  assign bus.req = w_req;
  assign bus.in_ready = w_ready;
  assign bus.starve = w_starve;
  assign bus.out_valid = r_ov;
  assign bus.out_data = r_od;
  assign bus.out_id = r_oid;
  assign bus.proto_err = r_perr;
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed stimulus with a behavioural slot/output model checked every cycle plus literal spot checks
module tb_arb_requester;
  import arb_requester_pkg::*;
  localparam int N = 32;
  localparam int DW = 8;
  localparam int SM = 64;
  localparam int IW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  arb_requester_if #(.N(N), .DW(DW)) bus ();
  arb_requester #(.N(N), .DW(DW), .STARVE_MAX(SM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [N-1:0] iv;
  logic [N-1:0] g_man;
  logic [N-1:0] rr_gnt;
  logic [N-1:0] m_req;
  logic [N-1:0] m_rdy;
  logic [N-1:0] m_stv;
  logic ordy;
  bit rr_mode;
  bit pat_mode;
  bit rec;
  bit chk_on;
  logic [DW-1:0] dval [N];
  logic [2:0] sc [N];
  logic [N*DW-1:0] tb_data;
  bit m_hv [N];
  logic [DW-1:0] m_hd [N];
  int m_cnt [N];
  bit m_ov;
  bit m_perr;
  logic [DW-1:0] m_od;
  logic [IW-1:0] m_oid;
  int rr_ptr;
  bit m_lg;
  int m_k;
  int n_chk;
  int n_fail;
  logic [IW-1:0] oid_q [$];
  logic [DW-1:0] od_q [$];
  assign bus.in_valid = iv;
  assign bus.in_data = tb_data;
  assign bus.out_ready = ordy;
  assign bus.gnt = rr_mode ? rr_gnt : g_man;
  always_comb begin
    tb_data = '0;
    for (int i = 0; i < N; i++) tb_data[i*DW +: DW] = pat_mode ? {5'(i), sc[i]} : dval[i];
  end
  always_comb begin
    m_req = '0;
    for (int i = 0; i < N; i++) m_req[i] = m_hv[i] && (!m_ov || ordy);
  end
  always_comb begin
    rr_gnt = '0;
    for (int k = N - 1; k >= 0; k--)
      if (m_req[(rr_ptr + k) % N]) begin
        rr_gnt = '0;
        rr_gnt[(rr_ptr + k) % N] = 1'b1;
      end
  end
  always_comb begin
    m_lg = (bus.gnt != '0) && ($countones(bus.gnt) == 1) && ((bus.gnt & ~m_req) == '0);
    m_k = 0;
    for (int i = 0; i < N; i++) if (bus.gnt[i]) m_k = i;
  end
  always_comb begin
    m_rdy = '0;
    m_stv = '0;
    for (int i = 0; i < N; i++) begin
      m_rdy[i] = !m_hv[i] || (m_lg && bus.gnt[i]);
      m_stv[i] = m_cnt[i] == SM;
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_hv[i] <= 1'b0;
        m_hd[i] <= '0;
        m_cnt[i] <= 0;
        sc[i] <= '0;
      end
      m_ov <= 1'b0;
      m_od <= '0;
      m_oid <= '0;
      m_perr <= 1'b0;
      rr_ptr <= 0;
    end else begin
      if (bus.gnt != '0 && !m_lg) m_perr <= 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!m_hv[i] || (m_lg && bus.gnt[i])) m_cnt[i] <= 0;
        else if (m_req[i] && !bus.gnt[i] && m_cnt[i] < SM) m_cnt[i] <= m_cnt[i] + 1;
        if (iv[i] && m_rdy[i]) begin
          m_hv[i] <= 1'b1;
          m_hd[i] <= tb_data[i*DW +: DW];
          sc[i] <= sc[i] + 3'd1;
        end else if (m_lg && bus.gnt[i]) m_hv[i] <= 1'b0;
      end
      if (m_lg) begin
        m_ov <= 1'b1;
        m_od <= m_hd[m_k];
        m_oid <= IW'(m_k);
        rr_ptr <= (m_k + 1) % N;
      end else if (ordy) m_ov <= 1'b0;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_rdy));
      chk("req", 64'(bus.req), 64'(m_req));
      chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
      chk("out_data", 64'(bus.out_data), 64'(m_od));
      chk("out_id", 64'(bus.out_id), 64'(m_oid));
      chk("starve", 64'(bus.starve), 64'(m_stv));
      chk("proto_err", 64'(bus.proto_err), 64'(m_perr));
    end
    if (rec && bus.out_valid && bus.out_ready) begin
      oid_q.push_back(bus.out_id);
      od_q.push_back(bus.out_data);
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask
  task automatic reset_dut();
    iv = '0;
    g_man = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    n_chk = 0;
    n_fail = 0;
    iv = '0;
    g_man = '0;
    ordy = 1'b1;
    rr_mode = 1'b0;
    pat_mode = 1'b0;
    rec = 1'b0;
    chk_on = 1'b0;
    for (int i = 0; i < N; i++) dval[i] = '0;
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_req", 64'(bus.req), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'hFFFF_FFFF);
    chk("rst_starve", 64'(bus.starve), 64'd0);
    chk("rst_proto_err", 64'(bus.proto_err), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_id", 64'(bus.out_id), 64'd0);
    chk_on = 1'b1;
    rst_n = 1'b1;
    rr_mode = 1'b1;
    iv[5] = 1'b1;
    dval[5] = 8'hA5;
    step();
    iv = '0;
    at_neg();
    chk("single_req", 64'(bus.req), 64'h20);
    chk("single_out_valid_early", 64'(bus.out_valid), 64'd0);
    step();
    at_neg();
    chk("single_out_valid", 64'(bus.out_valid), 64'd1);
    chk("single_out_data", 64'(bus.out_data), 64'hA5);
    chk("single_out_id", 64'(bus.out_id), 64'd5);
    chk("single_in_ready", 64'(bus.in_ready), 64'hFFFF_FFFF);
    reset_dut();
    rr_mode = 1'b0;
    ordy = 1'b0;
    iv[4] = 1'b1;
    dval[4] = 8'h44;
    step();
    iv = '0;
    iv[3] = 1'b1;
    dval[3] = 8'h33;
    g_man = 32'h10;
    step();
    iv = '0;
    g_man = '0;
    at_neg();
    chk("bp_req", 64'(bus.req), 64'd0);
    chk("bp_out_data", 64'(bus.out_data), 64'h44);
    chk("bp_out_id", 64'(bus.out_id), 64'd4);
    step();
    at_neg();
    chk("bp_hold_data", 64'(bus.out_data), 64'h44);
    chk("bp_hold_id", 64'(bus.out_id), 64'd4);
    step();
    ordy = 1'b1;
    g_man = 32'h8;
    at_neg();
    chk("bp_req_back", 64'(bus.req), 64'h8);
    step();
    g_man = '0;
    at_neg();
    chk("bp_next_data", 64'(bus.out_data), 64'h33);
    chk("bp_next_id", 64'(bus.out_id), 64'd3);
    reset_dut();
    iv = 32'h3;
    dval[0] = 8'h10;
    dval[1] = 8'h11;
    step();
    iv = '0;
    g_man = 32'h3;
    step();
    g_man = '0;
    at_neg();
    chk("multi_out_valid", 64'(bus.out_valid), 64'd0);
    chk("multi_proto_err", 64'(bus.proto_err), 64'd1);
    chk("multi_req_kept", 64'(bus.req), 64'h3);
    step();
    at_neg();
    chk("multi_sticky", 64'(bus.proto_err), 64'd1);
    reset_dut();
    chk("perr_cleared", 64'(bus.proto_err), 64'd0);
    g_man = 32'h80;
    step();
    g_man = '0;
    at_neg();
    chk("norq_proto_err", 64'(bus.proto_err), 64'd1);
    chk("norq_out_valid", 64'(bus.out_valid), 64'd0);
    reset_dut();
    iv[0] = 1'b1;
    dval[0] = 8'h5A;
    step();
    iv = '0;
    repeat (63) step();
    at_neg();
    chk("starve_63", 64'(bus.starve), 64'd0);
    step();
    at_neg();
    chk("starve_64", 64'(bus.starve), 64'd1);
    step();
    g_man = 32'h1;
    step();
    g_man = '0;
    at_neg();
    chk("starve_clear", 64'(bus.starve), 64'd0);
    chk("starve_out_data", 64'(bus.out_data), 64'h5A);
    reset_dut();
    rr_mode = 1'b1;
    pat_mode = 1'b1;
    iv = '1;
    rec = 1'b1;
    repeat (40) step();
    rec = 1'b0;
    iv = '0;
    chk("rr_count", 64'(oid_q.size() >= 33), 64'd1);
    for (int j = 0; j < 33 && j < oid_q.size(); j++) begin
      chk("rr_id", 64'(oid_q[j]), 64'(j % 32));
      chk("rr_data", 64'(od_q[j]), 64'({5'(j % 32), 3'(j / 32)}));
    end
    chk("rr_proto_err", 64'(bus.proto_err), 64'd0);
    reset_dut();
    pat_mode = 1'b0;
    ordy = 1'b0;
    iv = 32'h1F;
    step();
    iv = '0;
    step();
    at_neg();
    chk("mid_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_req", 64'(bus.req), 64'd0);
    chk("mid_starve", 64'(bus.starve), 64'd0);
    chk("mid_in_ready", 64'(bus.in_ready), 64'hFFFF_FFFF);
    step();
    rst_n = 1'b1;
    ordy = 1'b1;
    step();
    step();
    at_neg();
    chk("mid_no_replay", 64'(bus.out_valid), 64'd0);
    chk("mid_no_req", 64'(bus.req), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
